// File: rtl/display_bbox_if.sv
// Bus bundle between the detection post-processor, the bbox sender and the annotator.
interface display_bbox_if;
    logic [63:0] det_data_in;
    logic        det_data_in_valid;
    logic        det_commit;
    logic        frame_start;
    logic [63:0] bbox_data_out;
    logic        bbox_data_out_valid;
    logic        busy;
    logic        det_overflow;

    modport master (
        output det_data_in, det_data_in_valid, det_commit, frame_start,
        input  bbox_data_out, bbox_data_out_valid, busy, det_overflow
    );

    modport slave (
        input  det_data_in, det_data_in_valid, det_commit, frame_start,
        output bbox_data_out, bbox_data_out_valid, busy, det_overflow
    );
endinterface

// File: rtl/display_bbox_sender.sv
// Frame-synchronous bounding-box transmitter: sanitises detections into a ping-pong
// buffer and emits exactly MAX_BBOX words per frame after each new commit.
module display_bbox_sender #(
    parameter int unsigned FRAME_WIDTH  = 16,
    parameter int unsigned FRAME_HEIGHT = 9,
    parameter int unsigned MAX_BBOX     = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    display_bbox_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(MAX_BBOX + 1);
    localparam int unsigned AW    = (MAX_BBOX > 1) ? $clog2(MAX_BBOX) : 1;
    localparam logic [15:0]      X_LIM = 16'(FRAME_WIDTH - 1);
    localparam logic [15:0]      Y_LIM = 16'(FRAME_HEIGHT - 1);
    localparam logic [IDX_W-1:0] N_SLOT = IDX_W'(MAX_BBOX);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(MAX_BBOX - 1);
    localparam logic [63:0]      EMPTY  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [15:0] x0;
        logic [15:0] y0;
        logic [15:0] x1;
        logic [15:0] y1;
    } bbox_t;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             bank_q, bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] cnt_q [2];
    logic [IDX_W-1:0] cnt_d [2];
    logic [IDX_W-1:0] slot_q, slot_d;
    logic             new_list_q, new_list_d;
    logic             pend_q, pend_d;
    logic [63:0]      out_q, out_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic [63:0]      mem [2][MAX_BBOX];

    bbox_t            din, san;
    logic [63:0]      san_word;
    logic [15:0]      x_lo, x_hi, y_lo, y_hi;
    logic             accept;
    logic             swap;
    logic [IDX_W-1:0] new_cnt;
    logic [IDX_W-1:0] nxt_slot;
    logic [IDX_W-1:0] first_cnt;
    logic [63:0]      first_word;
    logic [63:0]      next_word;

    function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Order each coordinate pair, clamp into the frame; x0 == FFFF marks an empty slot
    always_comb begin
        din  = bbox_t'(bus.det_data_in);
        x_lo = (din.x0 > din.x1) ? din.x1 : din.x0;
        x_hi = (din.x0 > din.x1) ? din.x0 : din.x1;
        y_lo = (din.y0 > din.y1) ? din.y1 : din.y0;
        y_hi = (din.y0 > din.y1) ? din.y0 : din.y1;
        san.x0 = clamp(x_lo, X_LIM);
        san.y0 = clamp(y_lo, Y_LIM);
        san.x1 = clamp(x_hi, X_LIM);
        san.y1 = clamp(y_hi, Y_LIM);
        if (din.x0 == 16'hFFFF) begin
            san = bbox_t'(EMPTY);
        end
    end

    assign san_word = san;
    assign accept   = bus.det_data_in_valid && (wr_idx_q < N_SLOT) && !pend_q;
    assign new_cnt  = wr_idx_q + IDX_W'(accept);
    assign nxt_slot = slot_q + IDX_W'(1);
    assign next_word = (nxt_slot < cnt_q[~bank_q]) ? mem[~bank_q][AW'(nxt_slot)] : EMPTY;

    // First burst word; a commit in the same IDLE cycle makes the current write bank the send bank
    always_comb begin
        if (bus.det_commit) begin
            first_cnt  = new_cnt;
            first_word = (accept && (wr_idx_q == '0)) ? san_word : mem[bank_q][AW'(0)];
        end else begin
            first_cnt  = cnt_q[~bank_q];
            first_word = mem[~bank_q][AW'(0)];
        end
        if (first_cnt == '0) begin
            first_word = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[bank_q][AW'(wr_idx_q)] <= san_word;
        end
    end

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        wr_idx_d   = wr_idx_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        new_list_d = new_list_q;
        pend_d     = pend_q;
        out_d      = out_q;
        valid_d    = 1'b0;
        ovf_d      = bus.det_data_in_valid && !accept;
        swap       = 1'b0;

        // Commits during a burst wait for the burst to finish
        case (state_q)
            IDLE: swap = bus.det_commit;
            SEND: begin
                if (slot_q == LAST) begin
                    swap   = bus.det_commit || pend_q;
                    pend_d = 1'b0;
                end else if (bus.det_commit) begin
                    pend_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (swap) begin
            cnt_d[bank_q] = new_cnt;
            bank_d        = ~bank_q;
            wr_idx_d      = '0;
            new_list_d    = 1'b1;
        end else if (accept) begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.frame_start && new_list_d) begin
                    state_d    = SEND;
                    new_list_d = 1'b0;
                    slot_d     = '0;
                    valid_d    = 1'b1;
                    out_d      = first_word;
                end
            end
            SEND: begin
                if (slot_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    slot_d  = nxt_slot;
                    valid_d = 1'b1;
                    out_d   = next_word;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bank_q     <= 1'b0;
            wr_idx_q   <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            slot_q     <= '0;
            new_list_q <= 1'b0;
            pend_q     <= 1'b0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            wr_idx_q   <= wr_idx_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            slot_q     <= slot_d;
            new_list_q <= new_list_d;
            pend_q     <= pend_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.bbox_data_out       = out_q;
    assign bus.bbox_data_out_valid = valid_q;
    assign bus.busy                = valid_q;
    assign bus.det_overflow        = ovf_q;

endmodule

// File: tb/tb_display_bbox_sender.sv
// Randomised and directed bench for display_bbox_sender against a queue-based list model.
module tb_display_bbox_sender;

    localparam int FW = 16;
    localparam int FH = 9;
    localparam int MB = 5;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst_n;

    display_bbox_if bus ();

    display_bbox_sender #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .MAX_BBOX    (MB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int ovf_seen;

    logic [63:0] m_wq   [$];
    logic [63:0] m_list [$];
    logic [63:0] m_out  [$];
    logic [63:0] seen   [$];
    logic [63:0] want   [$];
    bit          m_pend;
    bit          m_new;
    bit          exp_valid;
    bit          exp_ovf;
    logic [63:0] exp_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] box(input int x0, input int y0, input int x1, input int y1);
        return {16'(x0), 16'(y0), 16'(x1), 16'(y1)};
    endfunction

    function automatic int lim(input int v, input int top);
        return (v > top) ? top : v;
    endfunction

    // Reference sanitiser: order each pair, then clamp to the frame
    function automatic logic [63:0] m_san(input logic [63:0] d);
        int x0, y0, x1, y1;
        x0 = int'(d[63:48]);
        y0 = int'(d[47:32]);
        x1 = int'(d[31:16]);
        y1 = int'(d[15:0]);
        if (x0 == 65535) return ONES;
        return box(lim((x0 < x1) ? x0 : x1, FW - 1), lim((y0 < y1) ? y0 : y1, FH - 1),
                   lim((x0 < x1) ? x1 : x0, FW - 1), lim((y0 < y1) ? y1 : y0, FH - 1));
    endfunction

    task automatic model_reset();
        m_wq.delete();
        m_list.delete();
        m_out.delete();
        m_pend    = 0;
        m_new     = 0;
        exp_valid = 0;
        exp_ovf   = 0;
        exp_data  = '0;
    endtask

    // One clock of list-level behaviour: m_out holds the words still owed in the current burst
    task automatic model_edge(input bit wv, input logic [63:0] d, input bit c, input bit fs);
        bit cur_send;
        bit last;
        bit acc;
        cur_send = exp_valid;
        last     = cur_send && (m_out.size() == 0);
        acc      = wv && (m_wq.size() < MB) && !m_pend;
        exp_ovf  = wv && !acc;
        if (acc) m_wq.push_back(m_san(d));
        if ((!cur_send && c) || (last && (c || m_pend))) begin
            m_list = m_wq;
            m_wq.delete();
            m_new  = 1;
            m_pend = 0;
        end else if (cur_send && c) begin
            m_pend = 1;
        end
        if (!cur_send && fs && m_new) begin
            m_new = 0;
            for (int i = 0; i < MB; i++) m_out.push_back((i < m_list.size()) ? m_list[i] : ONES);
        end
        if (m_out.size() > 0) begin
            exp_valid = 1;
            exp_data  = m_out.pop_front();
        end else begin
            exp_valid = 0;
        end
    endtask

    task automatic step(input bit wv, input logic [63:0] d, input bit c, input bit fs);
        bus.det_data_in_valid = wv;
        bus.det_data_in       = d;
        bus.det_commit        = c;
        bus.frame_start       = fs;
        @(posedge clk);
        model_edge(wv, d, c, fs);
        #1;
        check("valid", 64'(bus.bbox_data_out_valid), 64'(exp_valid));
        check("busy", 64'(bus.busy), 64'(exp_valid));
        check("overflow", 64'(bus.det_overflow), 64'(exp_ovf));
        if (exp_valid) check("data", bus.bbox_data_out, exp_data);
        if (bus.bbox_data_out_valid) seen.push_back(bus.bbox_data_out);
        if (bus.det_overflow) ovf_seen++;
    endtask

    task automatic wr(input logic [63:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic commit();
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic frame();
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic check_burst(input string tag);
        check({tag, "_len"}, 64'(seen.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < seen.size(); i++) check(tag, seen[i], want[i]);
        seen.delete();
        want.delete();
    endtask

    task automatic want_ones(input int n);
        for (int i = 0; i < n; i++) want.push_back(ONES);
    endtask

    initial begin
        clk = 0;
        rst_n = 0;
        bus.det_data_in = '0;
        bus.det_data_in_valid = 0;
        bus.det_commit = 0;
        bus.frame_start = 0;
        n_checks = 0;
        n_errors = 0;
        ovf_seen = 0;
        model_reset();

        #12;
        check("rst_valid", 64'(bus.bbox_data_out_valid), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_ovf", 64'(bus.det_overflow), 64'(0));
        check("rst_data", bus.bbox_data_out, 64'(0));
        @(negedge clk);
        rst_n = 1;

        // basic burst
        seen.delete();
        wr(box(2, 1, 10, 6));
        wr(box(3, 3, 5, 4));
        commit();
        frame();
        idle(7);
        want.push_back(box(2, 1, 10, 6));
        want.push_back(box(3, 3, 5, 4));
        want_ones(3);
        check_burst("basic");

        // sanitise
        wr(box(12, 8, 4, 2));
        wr(box(20, 3, 30, 15));
        wr(box(65535, 0, 0, 0));
        commit();
        frame();
        idle(7);
        want.push_back(box(4, 2, 12, 8));
        want.push_back(box(15, 3, 15, 8));
        want_ones(3);
        check_burst("sanitise");

        // overflow: 7 writes, only 5 fit
        ovf_seen = 0;
        for (int i = 0; i < 7; i++) wr(box(i, i, i + 2, i + 1));
        commit();
        check("ovf_pulses", 64'(ovf_seen), 64'(2));
        frame();
        idle(7);
        for (int i = 0; i < 5; i++) want.push_back(box(i, i, i + 2, i + 1));
        check_burst("overflow");

        // frame without commit, then empty commit
        frame();
        idle(7);
        check_burst("nocommit");
        commit();
        frame();
        idle(7);
        want_ones(5);
        check_burst("empty");

        // commit during a burst is deferred
        wr(box(1, 1, 2, 2));
        commit();
        wr(box(4, 4, 6, 6));
        wr(box(7, 0, 9, 3));
        seen.delete();
        frame();
        idle(1);
        commit();
        ovf_seen = 0;
        wr(box(11, 5, 13, 6));
        idle(6);
        check("defer_ovf", 64'(ovf_seen), 64'(1));
        want.push_back(box(1, 1, 2, 2));
        want_ones(4);
        check_burst("defer_cur");
        frame();
        idle(7);
        want.push_back(box(4, 4, 6, 6));
        want.push_back(box(7, 0, 9, 3));
        want_ones(3);
        check_burst("defer_next");

        // reset in the middle of a burst
        wr(box(5, 5, 6, 6));
        commit();
        frame();
        idle(2);
        rst_n = 0;
        #1;
        check("midrst_valid", 64'(bus.bbox_data_out_valid), 64'(0));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        model_reset();
        seen.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        frame();
        idle(7);
        check_burst("post_reset");

        // randomised traffic
        for (int n = 0; n < 800; n++) begin
            logic [63:0] d;
            bit wv, c, fs;
            wv = ($urandom_range(0, 9) < 4);
            c  = ($urandom_range(0, 24) == 0);
            fs = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0) begin
                d = {16'hFFFF, 48'($urandom)};
            end else if ($urandom_range(0, 7) == 0) begin
                d = {32'($urandom), 32'($urandom)};
            end else begin
                d = box(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
            end
            step(wv, d, c, fs);
        end
        seen.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
